io_handshake_port: RTL
======================

// Module: io_handshake_port
// PURPOSE
//  Registered bidirectional bus port with per-direction handshake flags. Sits directly
//  upstream of the am2948 inverting transceiver: side B drives/receives the transceiver's
//  A pins, side A faces the local data bus. Decouples CPU and system-bus timing.
// PARAMETERS
//  WIDTH   8   data path width of both registers and both buses
// PORTS
//  clk     in     1      rising-edge clock, sole clock
//  rst_    in     1      asynchronous active-low reset
//  a       inout  WIDTH  local bus; driven with S register while oea_=0, else Z
//  b       inout  WIDTH  transceiver-side bus; driven with R register while oeb_=0, else Z
//  lda_    in     1      load R from a at clk edge (active low)
//  ldb_    in     1      load S from b at clk edge (active low)
//  oea_    in     1      tristate enable of a (active low, combinational)
//  oeb_    in     1      tristate enable of b (active low, combinational)
//  ackr_   in     1      B side consumed R: clear fr (active low, sampled at clk)
//  acks_   in     1      A side consumed S: clear fs (active low, sampled at clk)
//  fr      out    1      R holds unread data (A->B direction full)
//  fs      out    1      S holds unread data (B->A direction full)
//  ovr     out    1      sticky overrun: a load was refused because its flag was set
//  irq_    out    1      only with IRQ_EN: active-low request, see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst_=0, async): R=S=0, fr=fs=ovr=0, irq_=1; a,b forced Z regardless of oe.
//  - Load: lda_=0 at edge and fr=0 -> R<=a, fr<=1. Data valid on b (if oeb_=0) after edge,
//    latency 1 clk. ldb_/S/fs symmetric.
//  - Overrun: lda_=0 with fr=1 and ackr_=1 -> R unchanged, fr stays 1, ovr<=1. Same for S.
//  - ovr clears only on reset or when both fr and fs are 0 at an edge with no load active.
//  - Simultaneous load+ack same edge (lda_=0, ackr_=0, fr=1): R<=a, fr stays 1, no overrun.
//  - Ack with flag clear: no effect. Ack alone: flag<=0, register data retained.
//  - Output enables purely combinational: drive/release within same cycle, no clock needed.
//  - lda_=0 and oea_=0 together: R captures the value on a (i.e. S); legal, no special case.
//  - oeb_=0 while external driver active on b: contention, user error, not detected.
//  - Both directions fully independent; any mix of the four strobes per cycle is legal.
//  - Reset mid-transfer: registers and flags cleared immediately; pending data is lost.
// CONFIGURATION
//  - IRQ_EN defined: port irq_ present; irq_ registered, irq_<=~(fr_next|fs_next|ovr_next),
//    i.e. asserted in the same cycle the flag becomes visible; reset value 1.
//  - IRQ_EN undefined: irq_ port and its register absent; all other behaviour identical.
// STRUCTURE
//  - Shared include am29xx_defs.vh: default WIDTH, active-low level constants (ASSERT_=0,
//    DEASSERT_=1), tristate value macro for WIDTH-wide Z.
//  - Sub-module hs_reg (WIDTH): one data register + full flag + overrun bit with load/ack
//    rules above; instantiated twice (R path a->b, S path b->a). Top adds tristate
//    drivers, ovr combine/clear and optional irq_.
// TESTING
//  1 reset: rst_=0 with oea_=oeb_=0 -> a=b=Z, fr=fs=ovr=0, irq_=1; release rst_ -> unchanged.
//  2 A->B: a=8'h33, lda_=0 one clk, then oeb_=0 -> fr=1, b=8'h33; ackr_=0 one clk -> fr=0,
//    b still 8'h33.
//  3 B->A: b=8'h55, ldb_=0, oea_=0 after edge -> fs=1, a=8'h55, irq_=0 (IRQ_EN); acks_=0 ->
//    fs=0, irq_=1.
//  4 overrun: load 8'hA5, then a=8'h5A lda_=0 without ack -> R=8'hA5, ovr=1; ack -> fr=0,
//    next idle edge ovr=0.
//  5 load+ack same edge with fr=1: a=8'hC3 -> R=8'hC3, fr=1, ovr=0.
//  6 chain with am2948 (tr_=0): R=8'h33, oeb_=0 -> transceiver far side 8'hCC; async
//    rst_ pulse mid-transfer -> b=Z, fr=0 same cycle.

Source files
------------

// File: rtl/io_handshake_port_pkg.sv
// rtl/io_handshake_port_pkg.sv - shared widths, active-low levels and handshake register rules
package io_handshake_port_pkg;

    localparam int   WIDTH_DEFAULT = 8;
    localparam logic ASSERT_       = 1'b0;
    localparam logic DEASSERT_     = 1'b1;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_LOAD,
        HS_OVERRUN,
        HS_ACK
    } hs_op_e;

    // An ack on the same edge frees the slot, so a concurrent load is accepted.
    function automatic hs_op_e hs_decode(input logic ld_, input logic ack_, input logic full);
        if (ld_ == ASSERT_ && (!full || ack_ == ASSERT_)) return HS_LOAD;
        if (ld_ == ASSERT_) return HS_OVERRUN;
        if (ack_ == ASSERT_) return HS_ACK;
        return HS_IDLE;
    endfunction

    function automatic logic hs_full_next(input hs_op_e op, input logic full);
        case (op)
            HS_LOAD, HS_OVERRUN: return 1'b1;
            HS_ACK:              return 1'b0;
            default:             return full;
        endcase
    endfunction

    function automatic logic hs_ovr_next(input hs_op_e op, input logic ovr, input logic clr);
        if (op == HS_OVERRUN) return 1'b1;
        return clr ? 1'b0 : ovr;
    endfunction

endpackage

// File: rtl/io_handshake_port_if.sv
// rtl/io_handshake_port_if.sv - strobe/flag bundle of the port; irq_ present only with IRQ_EN
interface io_handshake_port_if;

    logic lda_;
    logic ldb_;
    logic oea_;
    logic oeb_;
    logic ackr_;
    logic acks_;
    logic fr;
    logic fs;
    logic ovr;
`ifdef IRQ_EN
    logic irq_;

    modport master (
        output lda_, ldb_, oea_, oeb_, ackr_, acks_,
        input  fr, fs, ovr, irq_
    );
    modport slave (
        input  lda_, ldb_, oea_, oeb_, ackr_, acks_,
        output fr, fs, ovr, irq_
    );
`else
    modport master (
        output lda_, ldb_, oea_, oeb_, ackr_, acks_,
        input  fr, fs, ovr
    );
    modport slave (
        input  lda_, ldb_, oea_, oeb_, ackr_, acks_,
        output fr, fs, ovr
    );
`endif

endinterface

// File: rtl/io_handshake_port_hs_reg.sv
// rtl/io_handshake_port_hs_reg.sv - one direction: data register, full flag and sticky overrun bit
module io_handshake_port_hs_reg
    import io_handshake_port_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ld_,
    input  logic             ack_,
    input  logic             clr_ovr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             ovr
);

    hs_op_e op;

    assign op = hs_decode(ld_, ack_, full);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            q    <= '0;
            full <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (op == HS_LOAD) begin
                q <= d;
            end
            full <= hs_full_next(op, full);
            ovr  <= hs_ovr_next(op, ovr, clr_ovr);
        end
    end

endmodule

// File: rtl/io_handshake_port.sv
// rtl/io_handshake_port.sv - registered bidirectional port with handshake flags; IRQ_EN adds irq_
module io_handshake_port
    import io_handshake_port_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    io_handshake_port_if.slave hs
);

    localparam logic [WIDTH-1:0] BUS_Z = {WIDTH{1'bz}};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] s_q;
    logic             fr;
    logic             fs;
    logic             ovr_r;
    logic             ovr_s;
    logic             clr_ovr;

    // Overrun history is dropped only once both directions are drained and quiet.
    assign clr_ovr = !fr && !fs && hs.lda_ == DEASSERT_ && hs.ldb_ == DEASSERT_;

    io_handshake_port_hs_reg #(.WIDTH(WIDTH)) u_r (
        .clk     (clk),
        .rst_    (rst_),
        .ld_     (hs.lda_),
        .ack_    (hs.ackr_),
        .clr_ovr (clr_ovr),
        .d       (a),
        .q       (r_q),
        .full    (fr),
        .ovr     (ovr_r)
    );

    io_handshake_port_hs_reg #(.WIDTH(WIDTH)) u_s (
        .clk     (clk),
        .rst_    (rst_),
        .ld_     (hs.ldb_),
        .ack_    (hs.acks_),
        .clr_ovr (clr_ovr),
        .d       (b),
        .q       (s_q),
        .full    (fs),
        .ovr     (ovr_s)
    );

    assign hs.fr  = fr;
    assign hs.fs  = fs;
    assign hs.ovr = ovr_r | ovr_s;

    // Reset releases both buses at once, independent of the enables.
    assign a = (rst_ && hs.oea_ == ASSERT_) ? s_q : BUS_Z;
    assign b = (rst_ && hs.oeb_ == ASSERT_) ? r_q : BUS_Z;

`ifdef IRQ_EN
    logic irq_q;
    logic any_next;

    assign any_next = hs_full_next(hs_decode(hs.lda_, hs.ackr_, fr), fr)
                    | hs_full_next(hs_decode(hs.ldb_, hs.acks_, fs), fs)
                    | hs_ovr_next(hs_decode(hs.lda_, hs.ackr_, fr), ovr_r, clr_ovr)
                    | hs_ovr_next(hs_decode(hs.ldb_, hs.acks_, fs), ovr_s, clr_ovr);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            irq_q <= DEASSERT_;
        end else begin
            irq_q <= ~any_next;
        end
    end

    assign hs.irq_ = irq_q;
`endif

endmodule
